fifo_wptr_full: RTL and testbench

- Write-side pointer and full-flag stage of the UART async FIFO, in the write clock domain.
- Keeps the binary write counter and drives the write-address and write-enable signals for the dual-port RAM.
- Publishes the registered Gray write pointer for the read domain to synchronise.
- Brings the read domain's Gray pointer in through a 2-flop synchroniser, then generates full, almost_full, fill level and a sticky overflow flag.

---
 rtl/fifo_wptr_full.sv | 93 +++++++++
 tb/tb_fifo_wptr_full.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full/almost-full flags and fill level
// for the UART async FIFO.
module fifo_wptr_full #(
  parameter int addr_size = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [addr_size:0]   rptr_gray_async,
  input  logic                 clr_overflow,
  output logic                 mem_we,
  output logic [addr_size-1:0] waddr,
  output logic [addr_size:0]   wptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [addr_size:0]   wr_level,
  output logic                 overflow
);

  localparam int W = addr_size + 1;
  localparam logic [addr_size:0] AF_TH =
    W'((1 << addr_size) - AF_MARGIN);

  logic [addr_size:0] wbin;
  logic [addr_size:0] wbin_next;
  logic [addr_size:0] wgray_next;
  logic [addr_size:0] rq1;
  logic [addr_size:0] rq2;
  logic [addr_size:0] rbin_s;
  logic [addr_size:0] full_tgt;
  logic [addr_size:0] lvl_next;
  logic               push;
  logic               full_next;
  logic               af_next;

  assign push       = wr_en & ~full;
  assign mem_we     = push;
  assign waddr      = wbin[addr_size-1:0];
  assign wbin_next  = wbin + {{addr_size{1'b0}}, push};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= addr_size; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  assign wr_level  = wbin - rbin_s;
  assign lvl_next  = wbin_next - rbin_s;
  assign full_tgt  = {~rq2[addr_size:addr_size-1],
                      rq2[addr_size-2:0]};
  assign full_next = (wgray_next == full_tgt);
  assign af_next   = (lvl_next >= AF_TH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rptr_gray_async;
      rq2 <= rq1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= af_next;
    end
  end

  // A push attempt while full wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en & full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full.
// Expected values are hand-computed for addr_size=8, AF_MARGIN=4.
module tb_fifo_wptr_full;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [8:0] rptr_gray_async;
  logic       clr_overflow;
  logic       mem_we;
  logic [7:0] waddr;
  logic [8:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [8:0] wr_level;
  logic       overflow;

  int total;
  int passed;

  fifo_wptr_full #(.addr_size(8), .AF_MARGIN(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_en           (wr_en),
    .rptr_gray_async (rptr_gray_async),
    .clr_overflow    (clr_overflow),
    .mem_we          (mem_we),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .wr_level        (wr_level),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    clr_overflow = 1'b0;
    rptr_gray_async = '0;
    step();
    step();
    total++;
    if ({wptr_gray, full, almost_full, overflow} !== 12'h000)
      $display("FAIL reset_regs got %h want 000",
               {wptr_gray, full, almost_full, overflow});
    else passed++;
    total++;
    if (wr_level !== 9'd0 || waddr !== 8'd0)
      $display("FAIL reset_level got %0d/%0d want 0/0",
               wr_level, waddr);
    else passed++;
    reset = 1'b0;
    wr_en = 1'b1;
    repeat (37) step();
    total++;
    if (waddr !== 8'd37 || wr_level !== 9'd37)
      $display("FAIL pre_reset got %0d/%0d want 37/37",
               waddr, wr_level);
    else passed++;
    total++;
    if (wptr_gray !== 9'h037)
      $display("FAIL pre_reset_gray got %h want 037", wptr_gray);
    else passed++;
    #2;
    wr_en = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({waddr, wr_level, wptr_gray} !== 26'd0)
      $display("FAIL async_reset got %h want 0",
               {waddr, wr_level, wptr_gray});
    else passed++;
    total++;
    if ({full, almost_full, overflow, mem_we} !== 4'b0000)
      $display("FAIL async_reset_flags got %b want 0000",
               {full, almost_full, overflow, mem_we});
    else passed++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_fill_almost_full();
    rptr_gray_async = 9'h000;
    wr_en = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      total++;
      if (mem_we !== 1'b1 || waddr !== 8'(i))
        $display("FAIL fill_we[%0d] got %b/%0d want 1/%0d",
                 i, mem_we, waddr, i);
      else passed++;
      if (i == 251) begin
        total++;
        if (almost_full !== 1'b0)
          $display("FAIL af_251 got %b want 0", almost_full);
        else passed++;
      end
      if (i == 252) begin
        total++;
        if (almost_full !== 1'b1)
          $display("FAIL af_252 got %b want 1", almost_full);
        else passed++;
      end
      step();
    end
    total++;
    if (full !== 1'b1 || wptr_gray !== 9'h180)
      $display("FAIL fill_full got %b/%h want 1/180",
               full, wptr_gray);
    else passed++;
    total++;
    if (wr_level !== 9'd256 || mem_we !== 1'b0)
      $display("FAIL fill_level got %0d/%b want 256/0",
               wr_level, mem_we);
    else passed++;
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    step();
    step();
    total++;
    if (mem_we !== 1'b0 || waddr !== 8'd0 || wr_level !== 9'd256)
      $display("FAIL ovf_hold got %b/%0d/%0d want 0/0/256",
               mem_we, waddr, wr_level);
    else passed++;
    total++;
    if (overflow !== 1'b1 || wptr_gray !== 9'h180)
      $display("FAIL ovf_set got %b/%h want 1/180",
               overflow, wptr_gray);
    else passed++;
    clr_overflow = 1'b1;
    step();
    total++;
    if (overflow !== 1'b1)
      $display("FAIL ovf_set_wins got %b want 1", overflow);
    else passed++;
    wr_en = 1'b0;
    step();
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear got %b want 0", overflow);
    else passed++;
  endtask

  task automatic test_wrap();
    rptr_gray_async = 9'h180;
    step();
    step();
    total++;
    if (wr_level !== 9'd0 || full !== 1'b1)
      $display("FAIL wrap_sync got %0d/%b want 0/1",
               wr_level, full);
    else passed++;
    step();
    total++;
    if (full !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL wrap_unfull got %b/%b want 0/0",
               full, almost_full);
    else passed++;
    wr_en = 1'b1;
    repeat (256) step();
    wr_en = 1'b0;
    #1;
    total++;
    if (wptr_gray !== 9'h000 || full !== 1'b1)
      $display("FAIL wrap_full got %h/%b want 000/1",
               wptr_gray, full);
    else passed++;
    total++;
    if (waddr !== 8'd0 || wr_level !== 9'd256)
      $display("FAIL wrap_addr got %0d/%0d want 0/256",
               waddr, wr_level);
    else passed++;
  endtask

  task automatic test_drain_sync();
    rptr_gray_async = 9'h181;
    step();
    total++;
    if (wr_level !== 9'd256 || full !== 1'b1)
      $display("FAIL drain_e1 got %0d/%b want 256/1",
               wr_level, full);
    else passed++;
    step();
    total++;
    if (wr_level !== 9'd255 || full !== 1'b1)
      $display("FAIL drain_e2 got %0d/%b want 255/1",
               wr_level, full);
    else passed++;
    step();
    total++;
    if (full !== 1'b0)
      $display("FAIL drain_e3 got %b want 0", full);
    else passed++;
    wr_en = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b1 || waddr !== 8'd0)
      $display("FAIL drain_push got %b/%0d want 1/0",
               mem_we, waddr);
    else passed++;
    step();
    wr_en = 1'b0;
    total++;
    if (full !== 1'b1 || wptr_gray !== 9'h001 ||
        wr_level !== 9'd256)
      $display("FAIL drain_refull got %b/%h/%0d want 1/001/256",
               full, wptr_gray, wr_level);
    else passed++;
  endtask

  task automatic test_back_to_back();
    #2;
    reset = 1'b1;
    rptr_gray_async = 9'h000;
    wr_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    total++;
    if (waddr !== 8'd2 || wptr_gray !== 9'h003 ||
        wr_level !== 9'd2)
      $display("FAIL release_push got %0d/%h/%0d want 2/003/2",
               waddr, wptr_gray, wr_level);
    else passed++;
    wr_en = 1'b0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_fill_almost_full();
    test_overflow();
    test_wrap();
    test_drain_sync();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
